datapath_seq: RTL and testbench

Parametrised successor to the 16-bit/8-register CPU datapath. It contains the register file, operand registers A/B, shifter, ALU, result register C and status register. The loada/loadb/loadc/loads/write strobes are no longer driven externally: an internal sequencer generates them from one operation descriptor, accepted over a valid/ready handshake. It adds a working overflow (V) flag, an arithmetic-shift-right mode, and parametrised data width and register count.

---
 rtl/datapath_pkg.sv | 36 +++
 rtl/datapath_seq_regfile.sv | 26 ++
 rtl/datapath_seq.sv | 162 ++++++++++++++++
 tb/tb_datapath_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
package datapath_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    VS_C      = 2'b00,
    VS_PC     = 2'b01,
    VS_SXIMM8 = 2'b10,
    VS_MDATA  = 2'b11
  } vsel_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  localparam int Z_BIT = 2;
  localparam int V_BIT = 1;
  localparam int N_BIT = 0;

endpackage

// File: rtl/datapath_seq_regfile.sv
module regfile_n #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [$clog2(NREGS)-1:0] writenum,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(NREGS)-1:0] readnum,
  output logic [WIDTH-1:0]         data_out
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/datapath_seq.sv
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMMW  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [1:0]               op_alu,
  input  logic [1:0]               op_shift,
  input  logic [$clog2(NREGS)-1:0] op_rd,
  input  logic [$clog2(NREGS)-1:0] op_rn,
  input  logic [$clog2(NREGS)-1:0] op_rm,
  input  logic                     op_asel,
  input  logic                     op_bsel,
  input  logic [IMMW-1:0]          op_imm,
  input  logic [1:0]               op_vsel,
  input  logic                     op_wb,
  input  logic [WIDTH-1:0]         sximm8,
  input  logic [WIDTH-1:0]         pc,
  input  logic [WIDTH-1:0]         mdata,
  output logic                     done,
  output logic [WIDTH-1:0]         c,
  output logic [2:0]               status
);

  localparam int RW = $clog2(NREGS);

  state_t           state;
  alu_op_t          q_alu;
  shift_t           q_shift;
  vsel_t            q_vsel;
  logic [RW-1:0]    q_rd, q_rn, q_rm;
  logic             q_asel, q_bsel, q_wb;
  logic [IMMW-1:0]  q_imm;

  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [2:0]       status_reg;

  logic [WIDTH-1:0] rf_out, wb_data, b_shift, b_in, alu_res;
  logic             v_flag;
  logic [RW-1:0]    readnum;
  logic             rf_write;

  // Single read port: LDA reads rn, LDB reads rm.
  assign readnum  = (state == S_LDB) ? q_rm : q_rn;
  assign rf_write = (state == S_WB) && q_wb;
  assign op_ready = (state == S_IDLE);
  assign done     = (state == S_WB);
  assign c        = c_reg;
  assign status   = status_reg;

  regfile_n #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (rf_write),
    .writenum (q_rd),
    .data_in  (wb_data),
    .readnum  (readnum),
    .data_out (rf_out)
  );

  always_comb begin
    b_shift = b_reg;
    case (q_shift)
      SH_NONE: b_shift = b_reg;
      SH_LSL1: b_shift = {b_reg[WIDTH-2:0], 1'b0};
      SH_LSR1: b_shift = {1'b0, b_reg[WIDTH-1:1]};
      SH_ASR1: b_shift = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
      default: b_shift = b_reg;
    endcase

    b_in = q_bsel ? WIDTH'($signed(q_imm)) : b_shift;

    alu_res = '0;
    v_flag  = 1'b0;
    case (q_alu)
      ALU_ADD: begin
        alu_res = a_reg + b_in;
        v_flag  = (a_reg[WIDTH-1] == b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = a_reg + ~b_in + WIDTH'(1);
        v_flag  = (a_reg[WIDTH-1] != b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      ALU_AND: alu_res = a_reg & b_in;
      ALU_MVN: alu_res = ~b_in;
      default: alu_res = '0;
    endcase

    wb_data = c_reg;
    case (q_vsel)
      VS_C:      wb_data = c_reg;
      VS_PC:     wb_data = pc;
      VS_SXIMM8: wb_data = sximm8;
      VS_MDATA:  wb_data = mdata;
      default:   wb_data = c_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      q_alu      <= ALU_ADD;
      q_shift    <= SH_NONE;
      q_vsel     <= VS_C;
      q_rd       <= '0;
      q_rn       <= '0;
      q_rm       <= '0;
      q_asel     <= 1'b0;
      q_bsel     <= 1'b0;
      q_wb       <= 1'b0;
      q_imm      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      status_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            q_alu   <= alu_op_t'(op_alu);
            q_shift <= shift_t'(op_shift);
            q_vsel  <= vsel_t'(op_vsel);
            q_rd    <= op_rd;
            q_rn    <= op_rn;
            q_rm    <= op_rm;
            q_asel  <= op_asel;
            q_bsel  <= op_bsel;
            q_wb    <= op_wb;
            q_imm   <= op_imm;
            state   <= (vsel_t'(op_vsel) == VS_C) ? S_LDA : S_WB;
          end
        end
        S_LDA: begin
          a_reg <= q_asel ? '0 : rf_out;
          state <= S_LDB;
        end
        S_LDB: begin
          b_reg <= rf_out;
          state <= S_EXEC;
        end
        S_EXEC: begin
          c_reg             <= alu_res;
          status_reg[Z_BIT] <= (alu_res == '0);
          status_reg[V_BIT] <= v_flag;
          status_reg[N_BIT] <= alu_res[WIDTH-1];
          state             <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
module tb_datapath_seq;

  typedef struct {
    logic [1:0]  alu;
    logic [1:0]  sh;
    logic [2:0]  rd, rn, rm;
    logic        asel, bsel;
    logic [4:0]  imm;
    logic [1:0]  vsel;
    logic        wb;
    logic [15:0] val;
    logic [15:0] exp_c;
    logic [2:0]  exp_st;
    logic        w8;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, op_valid;
  logic [1:0]  op_alu, op_shift, op_vsel;
  logic [2:0]  op_rd, op_rn, op_rm;
  logic        op_asel, op_bsel, op_wb;
  logic [4:0]  op_imm;
  logic [15:0] sximm8, pc, mdata;

  logic        op_ready, done;
  logic [15:0] c;
  logic [2:0]  status;
  logic        op_ready8, done8;
  logic [7:0]  c8;
  logic [2:0]  status8;

  int n_pass  = 0;
  int n_total = 0;
  vec_t tv16[$];
  vec_t tv8[$];

  always #5 clk = ~clk;

  datapath_seq #(.WIDTH(16), .NREGS(8), .IMMW(5)) dut16 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_alu(op_alu), .op_shift(op_shift), .op_rd(op_rd), .op_rn(op_rn), .op_rm(op_rm),
    .op_asel(op_asel), .op_bsel(op_bsel), .op_imm(op_imm), .op_vsel(op_vsel), .op_wb(op_wb),
    .sximm8(sximm8), .pc(pc), .mdata(mdata), .done(done), .c(c), .status(status)
  );

  datapath_seq #(.WIDTH(8), .NREGS(4), .IMMW(5)) dut8 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready8),
    .op_alu(op_alu), .op_shift(op_shift), .op_rd(op_rd[1:0]), .op_rn(op_rn[1:0]), .op_rm(op_rm[1:0]),
    .op_asel(op_asel), .op_bsel(op_bsel), .op_imm(op_imm), .op_vsel(op_vsel), .op_wb(op_wb),
    .sximm8(sximm8[7:0]), .pc(pc[7:0]), .mdata(mdata[7:0]), .done(done8), .c(c8), .status(status8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mv(input logic [1:0] vsel, input logic [2:0] rd, input logic [15:0] val,
                              input logic wb, input logic [15:0] ec, input logic [2:0] est, input logic w8);
    vec_t v;
    v = '{alu: 2'd0, sh: 2'd0, rd: rd, rn: 3'd0, rm: 3'd0, asel: 1'b0, bsel: 1'b0, imm: 5'd0,
          vsel: vsel, wb: wb, val: val, exp_c: ec, exp_st: est, w8: w8};
    return v;
  endfunction

  function automatic vec_t al(input logic [1:0] alu, input logic [1:0] sh, input logic [2:0] rd,
                              input logic [2:0] rn, input logic [2:0] rm, input logic asel, input logic bsel,
                              input logic [4:0] imm, input logic wb, input logic [15:0] ec,
                              input logic [2:0] est, input logic w8);
    vec_t v;
    v = '{alu: alu, sh: sh, rd: rd, rn: rn, rm: rm, asel: asel, bsel: bsel, imm: imm,
          vsel: 2'd0, wb: wb, val: 16'h0, exp_c: ec, exp_st: est, w8: w8};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    op_alu   = v.alu;
    op_shift = v.sh;
    op_rd    = v.rd;
    op_rn    = v.rn;
    op_rm    = v.rm;
    op_asel  = v.asel;
    op_bsel  = v.bsel;
    op_imm   = v.imm;
    op_vsel  = v.vsel;
    op_wb    = v.wb;
    sximm8   = (v.vsel == 2'b10) ? v.val : 16'hDEAD;
    pc       = (v.vsel == 2'b01) ? v.val : 16'hBEEF;
    mdata    = (v.vsel == 2'b11) ? v.val : 16'hCAFE;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    logic [15:0] ac;
    logic [2:0]  as;
    wait_ready();
    drive(v);
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(v.w8 ? done8 : done) && lat < 10);
    chk({tag, " latency"}, lat, (v.vsel == 2'b00) ? 4 : 1);
    ac = v.w8 ? {8'h00, c8} : c;
    as = v.w8 ? status8 : status;
    chk({tag, " c"}, ac, v.exp_c);
    chk({tag, " status"}, as, v.exp_st);
  endtask

  initial begin
    int lat;
    reset    = 1'b1;
    op_valid = 1'b0;
    drive(mv(2'd0, 3'd0, 16'h0, 1'b0, 16'h0, 3'b0, 1'b0));

    // 16-bit: moves, ALU ops, flags, shifts, readbacks (asel=1 ADD passes R[rm] to c)
    tv16.push_back(mv(2'd2, 3'd0, 16'd50,   1, 16'h0000, 3'b000, 0));
    tv16.push_back(mv(2'd2, 3'd1, 16'd21,   1, 16'h0000, 3'b000, 0));
    tv16.push_back(al(2'd0, 2'd0, 3'd2, 3'd0, 3'd1, 0, 0, 5'd0, 1, 16'd71,   3'b000, 0));
    tv16.push_back(al(2'd1, 2'd0, 3'd3, 3'd0, 3'd1, 0, 0, 5'd0, 1, 16'd29,   3'b000, 0));
    tv16.push_back(mv(2'd3, 3'd0, 16'h7FFF, 1, 16'd29,   3'b000, 0));
    tv16.push_back(mv(2'd2, 3'd1, 16'hFFFF, 1, 16'd29,   3'b000, 0));
    tv16.push_back(al(2'd1, 2'd0, 3'd2, 3'd0, 3'd1, 0, 0, 5'd0, 1, 16'h8000, 3'b011, 0));
    tv16.push_back(al(2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 1, 5'd1, 1, 16'h8000, 3'b011, 0));
    tv16.push_back(mv(2'd2, 3'd4, 16'hFFCA, 1, 16'h8000, 3'b011, 0));
    tv16.push_back(al(2'd0, 2'd3, 3'd5, 3'd0, 3'd4, 1, 0, 5'd0, 1, 16'hFFE5, 3'b001, 0));
    tv16.push_back(al(2'd0, 2'd2, 3'd5, 3'd0, 3'd4, 1, 0, 5'd0, 1, 16'h7FE5, 3'b000, 0));
    tv16.push_back(al(2'd1, 2'd0, 3'd6, 3'd6, 3'd6, 0, 0, 5'd0, 1, 16'h0000, 3'b100, 0));
    tv16.push_back(mv(2'd2, 3'd3, 16'd99,   0, 16'h0000, 3'b100, 0));
    tv16.push_back(mv(2'd1, 3'd7, 16'h1234, 1, 16'h0000, 3'b100, 0));
    tv16.push_back(al(2'd0, 2'd0, 3'd7, 3'd0, 3'd2, 1, 0, 5'd0, 0, 16'h8000, 3'b001, 0));
    tv16.push_back(al(2'd0, 2'd0, 3'd7, 3'd0, 3'd3, 1, 0, 5'd0, 0, 16'h001D, 3'b000, 0));
    tv16.push_back(al(2'd0, 2'd0, 3'd7, 3'd0, 3'd0, 1, 0, 5'd0, 0, 16'h8000, 3'b001, 0));
    tv16.push_back(al(2'd0, 2'd0, 3'd6, 3'd0, 3'd7, 1, 0, 5'd0, 0, 16'h1234, 3'b000, 0));
    tv16.push_back(al(2'd2, 2'd0, 3'd6, 3'd1, 3'd3, 0, 0, 5'd0, 0, 16'h001D, 3'b000, 0));
    tv16.push_back(al(2'd2, 2'd0, 3'd6, 3'd0, 3'd1, 0, 0, 5'd0, 0, 16'h8000, 3'b001, 0));
    tv16.push_back(al(2'd3, 2'd0, 3'd6, 3'd0, 3'd0, 0, 1, 5'h10, 0, 16'h000F, 3'b000, 0));
    tv16.push_back(al(2'd3, 2'd0, 3'd6, 3'd2, 3'd1, 0, 0, 5'd0, 0, 16'h0000, 3'b100, 0));
    tv16.push_back(al(2'd0, 2'd1, 3'd6, 3'd0, 3'd4, 1, 0, 5'd0, 0, 16'hFF94, 3'b001, 0));
    tv16.push_back(al(2'd1, 2'd0, 3'd6, 3'd0, 3'd0, 0, 1, 5'd1, 0, 16'h7FFF, 3'b010, 0));
    tv16.push_back(al(2'd0, 2'd0, 3'd6, 3'd0, 3'd1, 0, 0, 5'd0, 0, 16'h7FFF, 3'b010, 0));

    // 8-bit instance, run after a reset so its C/status start from a known state
    tv8.push_back(mv(2'd2, 3'd0, 16'h007F, 1, 16'h0000, 3'b100, 1));
    tv8.push_back(mv(2'd2, 3'd1, 16'h0001, 1, 16'h0000, 3'b100, 1));
    tv8.push_back(al(2'd0, 2'd0, 3'd2, 3'd0, 3'd1, 0, 0, 5'd0, 1, 16'h0080, 3'b011, 1));
    tv8.push_back(mv(2'd2, 3'd3, 16'h00A5, 1, 16'h0080, 3'b011, 1));
    tv8.push_back(al(2'd0, 2'd0, 3'd0, 3'd0, 3'd3, 1, 0, 5'd0, 0, 16'h00A5, 3'b001, 1));
    tv8.push_back(al(2'd0, 2'd0, 3'd0, 3'd0, 3'd2, 1, 0, 5'd0, 0, 16'h0080, 3'b001, 1));

    repeat (2) @(negedge clk);
    chk("reset op_ready", op_ready, 1);
    chk("reset done", done, 0);
    chk("reset c", c, 0);
    chk("reset status", status, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset op_ready", op_ready, 1);
    chk("post-reset c8", c8, 0);

    foreach (tv16[i]) run_op(tv16[i], $sformatf("w16 row%0d", i));

    // Backpressure: op2 fields held on the bus during op1 must not leak into it
    wait_ready();
    drive(al(2'd0, 2'd0, 3'd6, 3'd0, 3'd3, 0, 0, 5'd0, 1, 16'h0, 3'b0, 0));
    op_valid = 1'b1;
    @(posedge clk);
    #1 drive(al(2'd1, 2'd0, 3'd7, 3'd3, 3'd3, 0, 0, 5'd0, 1, 16'h0, 3'b0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp busy %0d", i), op_ready, 0);
    end
    @(negedge clk);
    chk("bp op1 done", done, 1);
    chk("bp wb ready", op_ready, 0);
    chk("bp op1 c", c, 16'h801D);
    chk("bp op1 status", status, 3'b001);
    @(negedge clk);
    chk("bp idle ready", op_ready, 1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    chk("bp op2 accepted", op_ready, 0);
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("bp op2 latency", lat, 4);
    chk("bp op2 c", c, 16'h0000);
    chk("bp op2 status", status, 3'b100);
    run_op(al(2'd0, 2'd0, 3'd0, 3'd0, 3'd7, 1, 0, 5'd0, 0, 16'h0000, 3'b100, 0), "bp read R7");
    run_op(al(2'd0, 2'd0, 3'd0, 3'd0, 3'd6, 1, 0, 5'd0, 0, 16'h801D, 3'b001, 0), "bp read R6");

    // Reset asserted while in EXEC
    wait_ready();
    drive(al(2'd0, 2'd0, 3'd5, 3'd0, 3'd3, 0, 0, 5'd0, 1, 16'h0, 3'b0, 0));
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst mid-op busy", op_ready, 0);
    reset = 1'b1;
    #1;
    chk("rst op_ready", op_ready, 1);
    chk("rst done", done, 0);
    chk("rst c", c, 0);
    chk("rst status", status, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst no wb", done, 0);
    chk("rst still idle", op_ready, 1);
    run_op(al(2'd0, 2'd0, 3'd0, 3'd0, 3'd5, 1, 0, 5'd0, 0, 16'h0000, 3'b100, 0), "rst read R5");

    foreach (tv8[i]) run_op(tv8[i], $sformatf("w8 row%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
